// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, fetch FSM state encoding and the
// default halt opcode used by instruction_fetch.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_FULL   = 3'd3,
    S_HALTED = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one program-memory read per instruction, with a
// valid/ready hand-off to the decoder. Define IFETCH_HALT_DETECT_EN to stop on HALT_OPCODE.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                MEM_LATENCY = 1,
  parameter logic [DATA_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              halted
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  fetch_state_e      r_state, w_next;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_addr;
  logic              w_capture, w_hs, w_flush;

  // A halted core ignores flush; only reset brings it back.
  assign w_flush   = flush && (r_state != S_HALTED);
  assign w_capture = (r_state == S_WAIT) && (r_cnt <= 3'd1);
  assign w_hs      = (r_state == S_FULL) && instr_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (run) w_next = S_ADDR;
      S_ADDR: w_next = S_WAIT;
      S_WAIT: if (w_capture) w_next = S_FULL;
      S_FULL: if (w_hs) begin
        w_next = run ? S_ADDR : S_IDLE;
`ifdef IFETCH_HALT_DETECT_EN
        if (r_instr == HALT_OPCODE) w_next = S_HALTED;
`endif
      end
`ifdef IFETCH_HALT_DETECT_EN
      S_HALTED: w_next = S_HALTED;
`endif
      default: w_next = S_IDLE;
    endcase
    if (w_flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_instr      <= '0;
      r_instr_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ADDR)
        r_cnt <= LAT;
      else if (r_state == S_WAIT && r_cnt != 3'd0)
        r_cnt <= r_cnt - 3'd1;
      if (w_capture && !w_flush) begin
        r_instr      <= mem_rdata;
        r_instr_addr <= pc;
      end
    end
  end

  // pc_inc is the only combinational strobe that reset must mask in-cycle.
  assign pc_inc      = w_capture && !w_flush && !reset;
  assign mem_rd      = (r_state == S_ADDR);
  assign mem_addr    = mem_rd ? pc : '0;
  assign instr       = r_instr;
  assign instr_addr  = r_instr_addr;
  assign instr_valid = (r_state == S_FULL);
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALTED);

`ifdef IFETCH_HALT_DETECT_EN
  assign halted = (r_state == S_HALTED);
`else
  assign halted = 1'b0;
  logic w_unused_halt;
  assign w_unused_halt = ^HALT_OPCODE;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: u_dut1 (latency 1) carries most
// scenarios, u_dut3 (latency 3) covers capture-cycle flush and latency.
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, run1, flush1, rdy1, run3, flush3, rdy3;
  logic [7:0] pc1, pc3, addr1, addr3, rdata1, rdata3, instr1, instr3, iaddr1, iaddr3;
  logic [7:0] d3a, d3b, pc1_val, pc3_val;
  logic       inc1, inc3, rd1, rd3, vld1, vld3, busy1, busy3, halt1, halt3;
  logic       pc1_ld, pc3_ld;
  logic [7:0] mem_img [256];
  logic [15:0] q1 [$];
  int vecs = 0;
  int errs = 0;

  instruction_fetch #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .run(run1), .flush(flush1), .pc(pc1),
    .pc_inc(inc1), .mem_rd(rd1), .mem_addr(addr1), .mem_rdata(rdata1),
    .instr(instr1), .instr_addr(iaddr1), .instr_valid(vld1),
    .instr_ready(rdy1), .busy(busy1), .halted(halt1));

  instruction_fetch #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .run(run3), .flush(flush3), .pc(pc3),
    .pc_inc(inc3), .mem_rd(rd3), .mem_addr(addr3), .mem_rdata(rdata3),
    .instr(instr3), .instr_addr(iaddr3), .instr_valid(vld3),
    .instr_ready(rdy3), .busy(busy3), .halted(halt3));

  // Program memories and program counters owned by the bench.
  always @(posedge clk) begin
    rdata1 <= rd1 ? mem_img[addr1] : 8'h00;
    d3a    <= rd3 ? mem_img[addr3] : 8'h00;
    d3b    <= d3a;
    rdata3 <= d3b;
    if (pc1_ld) pc1 <= pc1_val; else if (inc1) pc1 <= pc1 + 8'd1;
    if (pc3_ld) pc3 <= pc3_val; else if (inc3) pc3 <= pc3 + 8'd1;
  end

  task automatic monitor1();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rd1) begin
        vecs++;
        if (addr1 !== pc1) begin errs++; $display("FAIL sb_mem_addr: got %h want %h", addr1, pc1); end
        q1.push_back({mem_img[pc1], pc1});
      end
      if (vld1 && rdy1 && !flush1) begin
        vecs++;
        if (q1.size() == 0) begin
          errs++; $display("FAIL sb_unexpected: instr %h addr %h with nothing expected", instr1, iaddr1);
        end else begin
          e = q1.pop_front();
          if ({instr1, iaddr1} !== e)
            begin errs++; $display("FAIL sb_instr: got %h/%h want %h/%h", instr1, iaddr1, e[15:8], e[7:0]); end
        end
      end
    end
  endtask

  task automatic load_pc1(input logic [7:0] v);
    pc1_val = v; pc1_ld = 1'b1;
    @(posedge clk); #1 pc1_ld = 1'b0;
  endtask

  task automatic wait_idle1();
    int t = 0;
    @(negedge clk);
    while (busy1 && t < 30) begin @(negedge clk); t++; end
    vecs++;
    if (busy1) begin errs++; $display("FAIL idle_timeout: busy %b want 0", busy1); end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid1(output bit ok);
    int t = 0;
    @(negedge clk);
    while (!vld1 && t < 30) begin @(negedge clk); t++; end
    ok = vld1;
    vecs++;
    if (!ok) begin errs++; $display("FAIL valid_timeout: instr_valid %b want 1", vld1); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vecs++; if ({rd1, inc1, vld1, busy1, halt1} !== 5'b0)
      begin errs++; $display("FAIL reset_strobes1: got %b want 00000", {rd1, inc1, vld1, busy1, halt1}); end
    vecs++; if ({addr1, instr1, iaddr1} !== 24'h0)
      begin errs++; $display("FAIL reset_data1: got %h want 000000", {addr1, instr1, iaddr1}); end
    vecs++; if ({rd3, inc3, vld3, busy3, halt3, addr3, instr3, iaddr3} !== 29'h0)
      begin errs++; $display("FAIL reset_dut3: got %h want 0", {rd3, inc3, vld3, busy3, halt3, addr3, instr3, iaddr3}); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if ({busy1, rd1} !== 2'b00)
      begin errs++; $display("FAIL idle_hold: busy/mem_rd %b want 00", {busy1, rd1}); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_pc1(8'h10);
    run1 = 1'b1; rdy1 = 1'b1;
    @(negedge clk);
    vecs++; if (rd1 !== 1'b0) begin errs++; $display("FAIL basic_c0_rd: got %b want 0", rd1); end
    @(negedge clk);
    vecs++; if ({rd1, addr1} !== {1'b1, 8'h10})
      begin errs++; $display("FAIL basic_c1_rd: got %b/%h want 1/10", rd1, addr1); end
    @(negedge clk);
    vecs++; if ({inc1, rd1, addr1} !== {2'b10, 8'h00})
      begin errs++; $display("FAIL basic_c2_inc: got %b/%b/%h want 1/0/00", inc1, rd1, addr1); end
    @(negedge clk);
    vecs++; if ({vld1, instr1, iaddr1, inc1} !== {1'b1, 8'hA5, 8'h10, 1'b0})
      begin errs++; $display("FAIL basic_c3_valid: got %b/%h/%h/%b want 1/a5/10/0", vld1, instr1, iaddr1, inc1); end
    @(posedge clk); #1 run1 = 1'b0;   // next fetch already in ADDR; it must still complete
    wait_idle1();
  endtask

  task automatic test_stall();
    bit ok;
    logic [15:0] e;
    rdy1 = 1'b0; run1 = 1'b1;
    wait_valid1(ok);
    if (ok) begin
      e = (q1.size() > 0) ? q1[0] : 16'hxxxx;
      repeat (5) begin
        vecs++;
        if ({vld1, instr1, iaddr1, rd1, inc1} !== {1'b1, e, 2'b00})
          begin errs++; $display("FAIL stall_hold: got %b/%h/%h/%b/%b want 1/%h/%h/0/0", vld1, instr1, iaddr1, rd1, inc1, e[15:8], e[7:0]); end
        @(negedge clk);
      end
    end
    @(posedge clk); #1 rdy1 = 1'b1; run1 = 1'b0;
    wait_idle1();
  endtask

  task automatic test_flush_handshake();
    bit ok;
    rdy1 = 1'b0; run1 = 1'b1;
    wait_valid1(ok);
    @(posedge clk); #1 flush1 = 1'b1; rdy1 = 1'b1;
    @(posedge clk); #1 flush1 = 1'b0; run1 = 1'b0;
    if (q1.size() > 0) void'(q1.pop_front());
    @(negedge clk);
    vecs++; if ({busy1, vld1, rd1} !== 3'b000)
      begin errs++; $display("FAIL flush_hs_idle: busy/valid/rd %b want 000", {busy1, vld1, rd1}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    int t = 0;
    load_pc1(8'h40);
    run1 = 1'b1; rdy1 = 1'b1;
    @(negedge clk);
    while (!rd1 && t < 10) begin @(negedge clk); t++; end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    vecs++; if (inc1 !== 1'b0) begin errs++; $display("FAIL rst_wait_inc: got %b want 0", inc1); end
    @(posedge clk); #1 reset = 1'b0; run1 = 1'b0;
    @(negedge clk);
    vecs++; if ({rd1, inc1, vld1, busy1, halt1, addr1, instr1, iaddr1} !== 29'h0)
      begin errs++; $display("FAIL rst_wait_outs: got %h want 0", {rd1, inc1, vld1, busy1, halt1, addr1, instr1, iaddr1}); end
    vecs++; if (pc1 !== 8'h40) begin errs++; $display("FAIL rst_wait_pc: got %h want 40", pc1); end
    q1.delete();
    @(posedge clk); #1 run1 = 1'b1;
    @(negedge clk); @(negedge clk);
    vecs++; if ({rd1, addr1} !== {1'b1, 8'h40})
      begin errs++; $display("FAIL rst_refetch: got %b/%h want 1/40", rd1, addr1); end
    @(posedge clk); #1 run1 = 1'b0;
    wait_idle1();
  endtask

  task automatic test_back_to_back();
    int n_rd = 0, n_inc = 0, n_hs = 0, c_a = 0, c_b = 0;
    logic [7:0] hs_addr [2];
    load_pc1(8'hFF);
    run1 = 1'b1; rdy1 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (rd1) begin n_rd++; if (n_rd == 1) c_a = c; else c_b = c; end
      if (inc1) n_inc++;
      if (vld1 && rdy1) begin if (n_hs < 2) hs_addr[n_hs] = iaddr1; n_hs++; end
      @(posedge clk); #1;
      if (n_rd >= 2) run1 = 1'b0;
    end
    vecs++; if (n_inc !== 2) begin errs++; $display("FAIL b2b_pc_inc: got %0d want 2", n_inc); end
    vecs++; if (c_b - c_a !== 3) begin errs++; $display("FAIL b2b_period: got %0d want 3", c_b - c_a); end
    vecs++; if (n_hs !== 2 || hs_addr[0] !== 8'hFF || hs_addr[1] !== 8'h00)
      begin errs++; $display("FAIL b2b_addrs: got %0d/%h/%h want 2/ff/00", n_hs, hs_addr[0], hs_addr[1]); end
  endtask

  task automatic test_flush_capture();
    int t = 0;
    run3 = 1'b1; rdy3 = 1'b1;
    @(negedge clk);
    while (!rd3 && t < 10) begin @(negedge clk); t++; end
    repeat (3) @(posedge clk);
    #1 flush3 = 1'b1; run3 = 1'b0;
    @(negedge clk);
    vecs++; if ({inc3, busy3} !== 2'b01)
      begin errs++; $display("FAIL flush_cap_inc: pc_inc/busy %b want 01", {inc3, busy3}); end
    @(posedge clk); #1 flush3 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vecs++; if ({vld3, busy3, rd3} !== 3'b000)
        begin errs++; $display("FAIL flush_cap_idle: valid/busy/rd %b want 000", {vld3, busy3, rd3}); end
    end
    vecs++; if ({instr3, pc3} !== {8'h00, 8'h20})
      begin errs++; $display("FAIL flush_cap_discard: instr/pc %h/%h want 00/20", instr3, pc3); end
    @(posedge clk); #1 run3 = 1'b1;
    @(posedge clk); #1 run3 = 1'b0;
    t = 1;
    @(negedge clk);
    while (!vld3 && t < 20) begin @(negedge clk); t++; end
    vecs++; if (t !== 5) begin errs++; $display("FAIL lat3_cycles: got %0d want 5", t); end
    vecs++; if ({instr3, iaddr3, pc3} !== {8'h7A, 8'h20, 8'h21})
      begin errs++; $display("FAIL lat3_data: got %h/%h/%h want 7a/20/21", instr3, iaddr3, pc3); end
    @(negedge clk);
    vecs++; if (busy3 !== 1'b0) begin errs++; $display("FAIL lat3_idle: busy %b want 0", busy3); end
  endtask

  task automatic test_halt();
    bit ok;
    load_pc1(8'hA5);
    run1 = 1'b1; rdy1 = 1'b1;
    wait_valid1(ok);
    vecs++; if (instr1 !== 8'hFF) begin errs++; $display("FAIL halt_instr: got %h want ff", instr1); end
`ifdef IFETCH_HALT_DETECT_EN
    @(posedge clk); #1 flush1 = 1'b1;
    @(negedge clk);
    vecs++; if ({halt1, busy1, vld1} !== 3'b100)
      begin errs++; $display("FAIL halt_enter: halted/busy/valid %b want 100", {halt1, busy1, vld1}); end
    repeat (5) begin
      @(negedge clk);
      vecs++; if ({halt1, rd1, inc1, vld1} !== 4'b1000)
        begin errs++; $display("FAIL halt_hold: halted/rd/inc/valid %b want 1000", {halt1, rd1, inc1, vld1}); end
    end
    @(posedge clk); #1 flush1 = 1'b0; run1 = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    vecs++; if (halt1 !== 1'b0) begin errs++; $display("FAIL halt_exit: halted %b want 0", halt1); end
    @(posedge clk); #1;
`else
    @(negedge clk);
    vecs++; if ({halt1, rd1, addr1} !== {2'b01, 8'hA6})
      begin errs++; $display("FAIL halt_ordinary: halted/rd/addr %b/%b/%h want 0/1/a6", halt1, rd1, addr1); end
    @(posedge clk); #1 run1 = 1'b0;
    wait_idle1();
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = 8'(i) ^ 8'h5A;
    mem_img[8'h10] = 8'hA5;
    reset = 1'b1; run1 = 1'b0; flush1 = 1'b0; rdy1 = 1'b0;
    run3 = 1'b0; flush3 = 1'b0; rdy3 = 1'b0;
    pc1_ld = 1'b1; pc1_val = 8'h00; pc3_ld = 1'b1; pc3_val = 8'h20;
    repeat (2) @(posedge clk);
    #1 pc1_ld = 1'b0; pc3_ld = 1'b0;
    fork monitor1(); join_none
    test_reset();
    test_basic();
    test_stall();
    test_flush_handshake();
    test_reset_in_wait();
    test_back_to_back();
    test_flush_capture();
    test_halt();
    vecs++;
    if (q1.size() != 0) begin errs++; $display("FAIL sb_leftover: %0d pending want 0", q1.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEM_LATENCY, default 1, program-memory read latency in cycles; legal range 1..4.
REQ-002 Parameter HALT_OPCODE, default 8'hFF, opcode that stops fetching.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port run, input, 1, fetch enable; level-sensitive.
REQ-006 Port flush, input, 1, synchronous discard of the held or in-flight instruction.
REQ-007 Port pc, input, 8, current program counter value.
REQ-008 Port pc_inc, output, 1, one-cycle increment strobe to the program counter enable.
REQ-009 Port mem_rd, output, 1, program-memory read strobe.
REQ-010 Port mem_addr, output, 8, program-memory address.
REQ-011 Port mem_rdata, input, 8, read data, valid MEM_LATENCY cycles after the mem_rd cycle.
REQ-012 Port instr, output, 8, fetched instruction byte.
REQ-013 Port instr_addr, output, 8, address instr was fetched from.
REQ-014 Port instr_valid, output, 1, instr/instr_addr hold a valid instruction.
REQ-015 Port instr_ready, input, 1, decoder accepts instruction.
REQ-016 Port busy, output, 1, high in any state except IDLE and HALTED.
REQ-017 Port halted, output, 1, fetch stopped on HALT_OPCODE.

Function
REQ-018 FSM states: IDLE, ADDR, WAIT, FULL, HALTED.
REQ-019 IDLE -> ADDR on run=1; IDLE holds while run=0.
REQ-020 ADDR: mem_rd=1, mem_addr=pc for exactly one cycle, latency counter loaded with MEM_LATENCY; next state WAIT.
REQ-021 WAIT: counter decrements each cycle; when it reaches 0, mem_rdata is captured into instr, pc into instr_addr, pc_inc=1 for that cycle only, next state FULL.
REQ-022 mem_rd and mem_addr are 0 outside ADDR.
REQ-023 FULL: instr_valid=1; instr and instr_addr stable while instr_valid=1 and instr_ready=0.
REQ-024 Handshake completes on instr_valid=1 and instr_ready=1; next state ADDR if run=1, else IDLE.
REQ-025 run deasserted in ADDR or WAIT does not abort; the fetch completes to FULL.
REQ-026 Throughput: one instruction per MEM_LATENCY+2 cycles with instr_ready held high.
REQ-027 pc_inc is asserted exactly once per captured instruction; never in any other state.
REQ-028 flush=1 in any state except HALTED: next state IDLE, instr_valid=0; on the capture cycle pc_inc is suppressed and the data discarded.
REQ-029 flush and handshake in the same cycle: flush wins; the instruction counts as consumed; next state IDLE.
REQ-030 pc wrap 8'hFF -> 8'h00 is owned by the program counter; fetch is unaffected.

Reset
REQ-031 reset=1 on a clock edge: state IDLE, counter 0, instr=0, instr_addr=0, all outputs 0.
REQ-032 reset overrides run, flush and any in-flight fetch; no pc_inc is issued for an aborted fetch.

Configuration
REQ-033 Macro IFETCH_HALT_DETECT_EN defined: after the handshake of an instruction equal to HALT_OPCODE, next state HALTED with halted=1; HALTED is exited only by reset; flush is ignored in HALTED.
REQ-034 Macro IFETCH_HALT_DETECT_EN undefined: HALTED state absent; halted tied 0; HALT_OPCODE is fetched as an ordinary instruction.

Structure
REQ-035 Shared package cpu_pkg holds ADDR_W=8, DATA_W=8, the fetch state enum typedef, and the default HALT_OPCODE constant.
REQ-036 No sub-module; the latency counter and FSM live inline in instruction_fetch.

Verification
REQ-037 MEM_LATENCY=1, pc=8'h10, run=1, ready=1, mem returns 8'hA5 -> mem_rd at cycle 1, instr=8'hA5, instr_addr=8'h10, pc_inc pulse at cycle 2, valid at cycle 3.
REQ-038 ready=0 for 5 cycles while valid -> instr stable; no mem_rd and no pc_inc until the handshake.
REQ-039 MEM_LATENCY=3, flush on the capture cycle -> no pc_inc; instr_valid stays 0; state IDLE.
REQ-040 reset asserted in WAIT -> next cycle all outputs 0; a later run=1 re-fetches from the current pc.
REQ-041 IFETCH_HALT_DETECT_EN defined, mem returns 8'hFF -> delivered once; halted=1 after the handshake; no further mem_rd with run=1 and flush=1 asserted.
REQ-042 pc=8'hFF, 2 back-to-back fetches -> instr_addr 8'hFF then 8'h00; exactly 2 pc_inc pulses.
